amp_ch_sched: RTL and testbench
===============================

AMP_CH_SCHED -- requirements
Module: amp_ch_sched

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 8, giving the number of audio channels that share one averaging engine; legal values are 2, 4, 8 or 16.
REQ-002 The module SHALL have derived parameter CH_W, default $clog2(NUM_CH), giving the width of the channel index.
REQ-003 The module SHALL have port clk, input, 1 bit: system clock (50 MHz), all logic on the rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port en, input, 1 bit: scheduler enable; 0 blocks new grants.
REQ-006 The module SHALL have port req, input, NUM_CH bits: per-channel new-sample-valid pulses.
REQ-007 The module SHALL have port ovrn_clr, input, 1 bit: clears all sticky overrun flags.
REQ-008 The module SHALL have port ch_sel, output, CH_W bits: channel index currently presented to the engine.
REQ-009 The module SHALL have port accum_en, output, 1 bit: one-cycle strobe that updates the selected channel's accumulator.
REQ-010 The module SHALL have port update_en, output, 1 bit: one-cycle strobe that updates the selected channel's amplitude register.
REQ-011 The module SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-012 The module SHALL have port ovrn, output, NUM_CH bits: sticky per-channel sample-overrun flags.

Function
REQ-013 The module SHALL hold a pending bit per channel; req[k]=1 sets pending[k] on the next edge.
REQ-014 The FSM SHALL have exactly three states, IDLE, ACCUM and UPDATE, and SHALL transition as follows:
- IDLE -> ACCUM when en=1 and any pending bit is set.
- ACCUM -> UPDATE unconditionally.
- UPDATE -> IDLE unconditionally.
REQ-015 On the IDLE->ACCUM edge, the module SHALL latch the granted index into ch_sel, clear that channel's pending bit, and load the round-robin pointer with that index.
REQ-016 Arbitration SHALL be round-robin: the search starts at pointer+1, wraps modulo NUM_CH, and the first pending channel found wins.
REQ-017 accum_en SHALL be 1 only in ACCUM, update_en SHALL be 1 only in UPDATE, and ch_sel SHALL stay stable from ACCUM through UPDATE.
REQ-018 Timing SHALL be as follows:
- req[k] at cycle t with the FSM in IDLE and en=1 gives accum_en at t+2, update_en at t+3 and IDLE at t+4.
- Maximum service rate is one channel per 3 cycles.
REQ-019 If req[k] coincides with the grant-clear of channel k, set SHALL win: pending[k] stays 1 and no overrun is flagged.
REQ-020 A req[k] arriving while pending[k] is already 1 and channel k is not being granted that cycle SHALL set ovrn[k]; the sample counts once.
REQ-021 ovrn_clr SHALL clear all ovrn bits; if a new overrun occurs in the same cycle, the set SHALL win.
REQ-022 Dropping en to 0 mid-sequence SHALL NOT abort ACCUM/UPDATE; it only inhibits the next grant, and pending bits keep accumulating.

Reset
REQ-023 While rst=1, on each clock edge the module SHALL set:
- state = IDLE;
- pending = 0, ovrn = 0;
- ch_sel = 0, accum_en = 0, update_en = 0, busy = 0;
- pointer = NUM_CH-1, so channel 0 is searched first.
REQ-024 rst asserted in ACCUM or UPDATE SHALL abandon the sequence, and the following cycle SHALL show no strobe.

Configuration
REQ-025 The macro AMP_SCHED_OVRN_EN SHALL control overrun detection:
- Defined: overrun detection, the ovrn register and ovrn_clr behave as in REQ-020/021.
- Undefined: the ovrn output is tied to 0, ovrn_clr is ignored, and no overrun flops exist.
- All other behaviour is identical in both builds.

Structure
REQ-026 Package amp_sched_pkg SHALL hold:
- the state_t enum (IDLE, ACCUM, UPDATE, one-hot 3-bit encoding);
- the NUM_CH default constant.
REQ-027 The round-robin pick SHALL be a combinational sub-module rr_arb, with inputs pending and pointer and outputs gnt_vld and gnt_idx; the FSM, pending, pointer and ovrn registers SHALL reside in amp_ch_sched.

Verification
REQ-028 Single request: reset, en=1, pulse req=8'h04 at t=0 -> ch_sel=2 with accum_en=1 at t=2, update_en=1 at t=3, busy low at t=4.
REQ-029 Round-robin: req=8'hFF for one cycle after reset -> grants in order 0,1,...,7, accum_en every 3 cycles, 8 accum_en and 8 update_en pulses in total.
REQ-030 Fairness after wrap: pointer=6 with req=8'h81 -> channel 7 is granted first, then channel 0.
REQ-031 Overrun: req[3] pulsed twice while channel 5 is being serviced -> ovrn=8'h08 and only one service of channel 3; then ovrn_clr=1 -> ovrn=0 next cycle.
REQ-032 Coincident set/clear: req[1] on the same edge that grants channel 1 -> channel 1 is serviced twice and ovrn[1]=0.
REQ-033 Reset mid-operation: assert rst in ACCUM with pending=8'h30 -> next cycle state=IDLE, pending=0, no update_en; after release, no grant without a new req.

Source files
------------

// File: rtl/amp_sched_pkg.sv
// +----------------------------------------------------------------------+
// | amp_sched_pkg: shared types and defaults for the amplitude scheduler |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package amp_sched_pkg;

  localparam int NUM_CH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    ACCUM  = 3'b010,
    UPDATE = 3'b100
  } state_t;

endpackage

`default_nettype wire

// File: rtl/amp_ch_sched_rr_arb.sv
// +----------------------------------------------------------------------+
// | rr_arb: combinational round-robin pick starting after the pointer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arb
  import amp_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [CH_W-1:0]   pointer,
  output logic              gnt_vld,
  output logic [CH_W-1:0]   gnt_idx
);

  logic [CH_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest hit wins;
  // the index width makes the wrap modulo NUM_CH implicit.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = pointer + CH_W'(i);
      if (pending[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/amp_ch_sched.sv
// +----------------------------------------------------------------------+
// | amp_ch_sched: round-robin scheduler sharing one averaging engine     |
// | Optional overrun detection enabled by macro AMP_SCHED_OVRN_EN.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module amp_ch_sched
  import amp_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] req,
  input  logic              ovrn_clr,
  output logic [CH_W-1:0]   ch_sel,
  output logic              accum_en,
  output logic              update_en,
  output logic              busy,
  output logic [NUM_CH-1:0] ovrn
);

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
  logic [NUM_CH-1:0] grant_mask;
  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_idx;

  rr_arb #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_arb (
    .pending (pending_q),
    .pointer (ptr_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ch_sel_d   = ch_sel_q;
    grant_mask = '0;
    case (state_q)
      IDLE: begin
        if (en && gnt_vld) begin
          state_d    = ACCUM;
          ch_sel_d   = gnt_idx;
          ptr_d      = gnt_idx;
          grant_mask = {{(NUM_CH-1){1'b0}}, 1'b1} << gnt_idx;
        end
      end
      ACCUM:   state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A new request on the granted channel re-arms it (set beats clear).
    pending_d = (pending_q & ~grant_mask) | req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ptr_q     <= CH_W'(NUM_CH - 1);
      ch_sel_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      ch_sel_q  <= ch_sel_d;
    end
  end

`ifdef AMP_SCHED_OVRN_EN
  logic [NUM_CH-1:0] ovrn_q, ovrn_d;

  // Clear first, then OR in new overruns so a coincident set survives.
  always_comb begin
    ovrn_d = (ovrn_clr ? '0 : ovrn_q) | (req & pending_q & ~grant_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovrn_q <= '0;
    end else begin
      ovrn_q <= ovrn_d;
    end
  end

  assign ovrn = ovrn_q;
`else
  logic unused_ovrn_clr;
  assign unused_ovrn_clr = ovrn_clr;
  assign ovrn            = '0;
`endif

  assign ch_sel    = ch_sel_q;
  assign accum_en  = (state_q == ACCUM);
  assign update_en = (state_q == UPDATE);
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_amp_ch_sched.sv
// +----------------------------------------------------------------------+
// | tb_amp_ch_sched: directed stimulus checked against a behavioural     |
// | scheduler model plus literal expectations. Rev 1.0                   |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_amp_ch_sched;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         ovrn_clr = 1'b0;
  logic [N-1:0] req = '0;
  logic [2:0]   ch_sel;
  logic         accum_en;
  logic         update_en;
  logic         busy;
  logic [N-1:0] ovrn;

  int n_vec = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  amp_ch_sched #(.NUM_CH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .ovrn_clr  (ovrn_clr),
    .ch_sel    (ch_sel),
    .accum_en  (accum_en),
    .update_en (update_en),
    .busy      (busy),
    .ovrn      (ovrn)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pending set, sticky overruns, pointer, and a
  // service phase counter (0 idle, 1 accumulate, 2 update).
  bit [N-1:0] m_pend, m_ovrn;
  int         m_ptr, m_phase, m_sel, m_g, m_c;
  bit         m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = '0; m_ovrn = '0; m_ptr = N - 1; m_phase = 0; m_sel = 0;
      m_valid = 1;
    end else begin
      m_g = -1;
      if (m_phase == 0 && en && m_pend != 0) begin
        for (int i = 1; i <= N; i++) begin
          m_c = (m_ptr + i) % N;
          if (m_g < 0 && m_pend[m_c]) m_g = m_c;
        end
      end
      if (ovrn_clr) m_ovrn = '0;
      for (int k = 0; k < N; k++) begin
        if (req[k] && m_pend[k] && k != m_g) m_ovrn[k] = 1'b1;
        m_pend[k] = (m_pend[k] && k != m_g) || req[k];
      end
      if (m_phase == 0) begin
        if (m_g >= 0) begin
          m_phase = 1; m_sel = m_g; m_ptr = m_g;
        end
      end else begin
        m_phase = (m_phase + 1) % 3;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("accum_en", 32'(accum_en), 32'(m_phase == 1));
      chk("update_en", 32'(update_en), 32'(m_phase == 2));
      chk("ch_sel", 32'(ch_sel), 32'(m_sel));
`ifdef AMP_SCHED_OVRN_EN
      chk("ovrn", 32'(ovrn), 32'(m_ovrn));
`else
      chk("ovrn", 32'(ovrn), 32'h0);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  int ord[16];
  int na, nu, last;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ch_sel", 32'(ch_sel), 0);
    chk("rst_accum", 32'(accum_en), 0);
    chk("rst_ovrn", 32'(ovrn), 0);
    rst = 1'b0; en = 1'b1;

    // Single request on channel 2
    req = 8'h04; tick(); req = '0;
    chk("single_t1_accum", 32'(accum_en), 0);
    tick();
    chk("single_t2_accum", 32'(accum_en), 1);
    chk("single_t2_sel", 32'(ch_sel), 2);
    tick();
    chk("single_t3_update", 32'(update_en), 1);
    tick();
    chk("single_t4_busy", 32'(busy), 0);

    // Full round-robin sweep after reset
    do_reset();
    req = 8'hFF; tick(); req = '0;
    na = 0; nu = 0; last = 0;
    for (int c = 0; c < 26; c++) begin
      tick();
      if (accum_en) begin
        if (na > 0) chk("rr_spacing", 32'(c - last), 3);
        if (na < 16) ord[na] = 32'(ch_sel);
        last = c; na++;
      end
      if (update_en) nu++;
    end
    chk("rr_accum_count", 32'(na), 8);
    chk("rr_update_count", 32'(nu), 8);
    for (int i = 0; i < 8; i++) chk("rr_order", 32'(ord[i]), 32'(i));

    // Fairness after wrap: pointer to 6, then 7 and 0 pending
    req = 8'h40; tick(); req = '0; tick();
    chk("wrap_sel6", 32'(ch_sel), 6);
    req = 8'h81; tick(); req = '0; tick(); tick();
    chk("wrap_first_accum", 32'(accum_en), 1);
    chk("wrap_first_sel7", 32'(ch_sel), 7);
    tick(); tick(); tick();
    chk("wrap_second_accum", 32'(accum_en), 1);
    chk("wrap_second_sel0", 32'(ch_sel), 0);
    tick(); tick();

    // Overrun on channel 3 while channel 5 is serviced
    req = 8'h20; tick(); req = '0; tick();
    chk("ovr_sel5", 32'(ch_sel), 5);
    req = 8'h08; tick(); tick(); req = '0;
`ifdef AMP_SCHED_OVRN_EN
    chk("ovr_flag", 32'(ovrn), 32'h08);
`else
    chk("ovr_flag_off", 32'(ovrn), 0);
`endif
    tick();
    chk("ovr_sel3", 32'(ch_sel), 3);
    chk("ovr_accum3", 32'(accum_en), 1);
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ovr_single_service", 32'(accum_en), 0);
    end
    ovrn_clr = 1'b1; tick(); ovrn_clr = 1'b0;
    chk("ovr_cleared", 32'(ovrn), 0);

    // Request coinciding with the grant of the same channel
    req = 8'h02; tick(); tick(); req = '0;
    chk("coin_sel1", 32'(ch_sel), 1);
    chk("coin_no_ovrn", 32'(ovrn), 0);
    tick(); tick(); tick();
    chk("coin_second_accum", 32'(accum_en), 1);
    chk("coin_second_sel1", 32'(ch_sel), 1);
    tick(); tick();

    // Reset in ACCUM with channels 4 and 5 pending
    req = 8'h01; tick(); req = 8'h30; tick(); req = '0;
    chk("rstmid_accum", 32'(accum_en), 1);
    rst = 1'b1; tick();
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_update", 32'(update_en), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstmid_no_grant", 32'(busy), 0);
    end

    // Dropping en mid-sequence finishes the service but holds the next grant
    req = 8'h04; tick(); req = '0; tick();
    en = 1'b0; req = 8'h10; tick(); req = '0;
    chk("en_update", 32'(update_en), 1);
    tick(); tick();
    chk("en_hold_idle", 32'(busy), 0);
    en = 1'b1; tick();
    chk("en_resume_sel4", 32'(ch_sel), 4);
    chk("en_resume_accum", 32'(accum_en), 1);
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
